// File: rtl/ex_mem_skid_pkg.sv
// Shared constants for the EX/MEM skid buffer: ctrl bit positions and FSM state encoding.
package ex_mem_skid_pkg;

    localparam int CTRL_REGW = 3;
    localparam int CTRL_MRD  = 2;
    localparam int CTRL_MWR  = 1;
    localparam int CTRL_BR   = 0;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/ex_mem_skid_entry.sv
// One pipeline entry register {result, zero, store_data, rd, ctrl}; cleared by reset, loaded when en.
module ex_mem_entry #(
    parameter int W = 74
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM two-entry skid buffer (head + skid register) with registered in_ready.
// Optional forwarding outputs are built when EX_MEM_SKID_FWD_EN is defined.
//
// Handshake: on each side an entry moves only on a rising edge where valid and
// ready are both high; valid never depends on ready, and flush overrides both sides.
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RDW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_zero,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [RDW-1:0]  in_rd,
    input  logic [3:0]      in_ctrl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [RDW-1:0]  out_rd,
    output logic [3:0]      out_ctrl,
    output logic            out_branch_taken,
    output logic [1:0]      dbg_state
`ifdef EX_MEM_SKID_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [RDW-1:0]  fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    localparam int EW = 2 * XLEN + RDW + 5;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          in_fire;
    logic          out_fire;
    logic          head_en;
    logic          skid_en;
    logic          head_zero;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_d;
    logic [EW-1:0] head_q;
    logic [EW-1:0] skid_q;

    assign in_entry  = {in_result, in_zero, in_store_data, in_rd, in_ctrl};
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        head_en = 1'b0;
        skid_en = 1'b0;
        head_d  = in_entry;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    head_en = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_en = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d = ONE;
                    head_en = 1'b1;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            head_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != FULL);
        end
    end

    ex_mem_entry #(.W(EW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (head_en),
        .d     (head_d),
        .q     (head_q)
    );

    ex_mem_entry #(.W(EW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign {out_result, head_zero, out_store_data, out_rd, out_ctrl} = head_q;

    // Stale head contents remain after a drain or flush, so gate with out_valid.
    assign out_branch_taken = out_valid && out_ctrl[CTRL_BR] && head_zero;

`ifdef EX_MEM_SKID_FWD_EN
    assign fwd_valid = out_valid && out_ctrl[CTRL_REGW] && !out_ctrl[CTRL_MRD] && (out_rd != '0);
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_result;
`endif

endmodule
